mem_bus_bridge: RTL and testbench

Downstream neighbour of the core's load/store RAM interface. It takes the word-aligned, byte-lane request that interface produces (`addr`, `w_data`, `wen`, `ren`) and routes it by address to one of two targets. The on-chip synchronous RAM gets a zero-wait passthrough. Everything else goes to a valid/ready peripheral port, with wait states, a stall back to the pipeline and a timeout watchdog. In both cases read data reaches the upstream stage the cycle after the request is accepted.

---
 rtl/mem_bus_bridge.sv | 122 ++++++++++++
 tb/tb_mem_bus_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: routes the core's load/store request to on-chip RAM (zero-wait)
// or to a valid/ready peripheral port with stall, timeout and sticky error.
`default_nettype none

module mem_bus_bridge #(
  parameter logic [3:0] RAM_REGION = 4'h0,
  parameter logic [7:0] TIMEOUT    = 8'd32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  wen,
  input  logic        ren,
  output logic [31:0] r_data,
  output logic        bus_stall,
  output logic        bus_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wen,
  output logic        ram_ren,
  input  logic [31:0] ram_rdata,
  output logic        p_valid,
  output logic        p_write,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  output logic [3:0]  p_wstrb,
  input  logic        p_ready,
  input  logic [31:0] p_rdata,
  input  logic        p_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREQ  = 2'd1,
    PDONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] rd_buf;
  logic        src_q;
  logic        req;
  logic        is_ram;
  logic        launch;
  logic        xfer_end;

  assign req    = ren | (|wen);
  assign is_ram = (addr[31:28] == RAM_REGION);
  assign launch = (state == IDLE) & req & ~is_ram;

  assign ram_addr  = addr;
  assign ram_wdata = w_data;
  assign ram_wen   = (is_ram && state == IDLE) ? wen : 4'h0;
  assign ram_ren   = ren & is_ram & (state == IDLE);

  assign bus_stall = launch | (state == PREQ);
  assign r_data    = src_q ? rd_buf : ram_rdata;

  // The wait counter holds the number of PREQ cycles already elapsed, so the
  // TIMEOUT-th cycle is the one where it equals TIMEOUT-1; p_ready is tested first.
  assign xfer_end = (state == PREQ) & (p_ready | (wait_cnt == TIMEOUT - 8'd1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      rd_buf   <= 32'h0;
      src_q    <= 1'b0;
      bus_err  <= 1'b0;
      p_valid  <= 1'b0;
      p_write  <= 1'b0;
      p_addr   <= 32'h0;
      p_wdata  <= 32'h0;
      p_wstrb  <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req & is_ram) begin
            src_q <= 1'b0;
          end
          if (launch) begin
            state    <= PREQ;
            wait_cnt <= 8'd0;
            p_valid  <= 1'b1;
            p_write  <= |wen;
            p_addr   <= addr;
            p_wdata  <= w_data;
            p_wstrb  <= wen;
          end
        end
        PREQ: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (p_ready) begin
            rd_buf  <= p_rdata;
            bus_err <= bus_err | p_err;
          end else if (xfer_end) begin
            rd_buf  <= 32'h0;
            bus_err <= 1'b1;
          end
          if (xfer_end) begin
            state   <= PDONE;
            p_valid <= 1'b0;
            p_write <= 1'b0;
            p_addr  <= 32'h0;
            p_wdata <= 32'h0;
            p_wstrb <= 4'h0;
          end
        end
        PDONE: begin
          // The request still held upstream is consumed here, never relaunched.
          state <= IDLE;
          src_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: scoreboard bench for mem_bus_bridge with a RAM model,
// a peripheral responder and a queue-based reference of responses and transfers.
`default_nettype none

module tb_mem_bus_bridge;

  localparam int TMO = 4;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  wen;
  logic        ren;
  logic [31:0] r_data;
  logic        bus_stall;
  logic        bus_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic        ram_ren;
  logic [31:0] ram_rdata;
  logic        p_valid;
  logic        p_write;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;
  logic        p_ready;
  logic [31:0] p_rdata;
  logic        p_err;

  mem_bus_bridge #(
    .RAM_REGION(4'h0),
    .TIMEOUT   (8'd4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .addr     (addr),
    .w_data   (w_data),
    .wen      (wen),
    .ren      (ren),
    .r_data   (r_data),
    .bus_stall(bus_stall),
    .bus_err  (bus_err),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wen  (ram_wen),
    .ram_ren  (ram_ren),
    .ram_rdata(ram_rdata),
    .p_valid  (p_valid),
    .p_write  (p_write),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_wstrb  (p_wstrb),
    .p_ready  (p_ready),
    .p_rdata  (p_rdata),
    .p_err    (p_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [7:0]  len;
  } xfer_t;

  resp_t       sq[$];
  xfer_t       pq[$];
  logic [31:0] ref_mem [16];
  logic [31:0] env_mem [16];
  logic        err_model;
  int          resp_k;
  logic [31:0] resp_data;
  logic        resp_err;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // On-chip synchronous RAM seen by the bridge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) env_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_ren) ram_rdata <= env_mem[ram_addr[5:2]];
  end

  // Peripheral responder: answers on the resp_k-th p_valid cycle, garbage otherwise.
  initial begin
    int c;
    c = 0;
    p_ready = 1'b0;
    p_rdata = 32'h0;
    p_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (p_valid) begin
        c++;
        p_ready = (c == resp_k);
        p_rdata = (c == resp_k) ? resp_data : $urandom;
        p_err   = (c == resp_k) ? resp_err : 1'($urandom_range(0, 1));
      end else begin
        c = 0;
        p_ready = 1'b0;
      end
    end
  end

  // Response monitor: data/err are due the cycle after an accepted request.
  initial begin
    bit    pend;
    resp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (sq.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          if (e.chk_data) chk("r_data", r_data, e.data);
          chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
        end
      end
      pend = rstn && (ren || wen != 4'h0) && !bus_stall;
    end
  end

  // Peripheral-port monitor: one transfer per expected entry, exact p_valid length.
  initial begin
    int    cnt;
    xfer_t x;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (p_valid) begin
        if (cnt == 0) begin
          if (pq.size() == 0) begin
            chk("p_extra_xfer", 32'd1, 32'd0);
          end else begin
            x = pq[0];
            chk("p_addr", p_addr, x.addr);
            chk("p_write", {31'h0, p_write}, {31'h0, x.write});
            chk("p_wstrb", {28'h0, p_wstrb}, {28'h0, x.wstrb});
            chk("p_wdata", p_wdata, x.wdata);
          end
        end
        cnt++;
      end else begin
        if (cnt != 0 && pq.size() != 0) begin
          x = pq.pop_front();
          chk("p_valid_len", cnt, {24'h0, x.len});
        end
        cnt = 0;
        chk("p_idle_zero", {p_write, p_wstrb, 27'h0} | p_addr | p_wdata, 32'h0);
      end
    end
  end

  task automatic idle(input int n);
    addr = $urandom; w_data = $urandom; wen = 4'h0; ren = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request (called #1 after a posedge); returns #1 after the posedge
  // that follows the cycle in which the bridge consumed it.
  task automatic do_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input logic re, input int k, input logic [31:0] pd, input logic pe);
    resp_t e;
    xfer_t x;
    bit    is_ram;
    int    len;
    int    stalls;
    is_ram = (a[31:28] == 4'h0);
    e.chk_data = (we == 4'h0);
    e.data = 32'h0;
    len = 0;
    if (is_ram) begin
      if (we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.data = ref_mem[a[5:2]];
      end
    end else begin
      if (k <= TMO) begin
        e.data = pd;
        len = k;
        if (pe) err_model = 1'b1;
      end else begin
        e.data = 32'h0;
        len = TMO;
        err_model = 1'b1;
      end
      x.addr = a; x.write = (we != 4'h0); x.wstrb = we; x.wdata = d; x.len = 8'(len);
      pq.push_back(x);
      resp_k = k; resp_data = pd; resp_err = pe;
    end
    e.err = err_model;
    sq.push_back(e);
    addr = a; w_data = d; wen = we; ren = re;
    @(negedge clk);
    chk("ram_wen", {28'h0, ram_wen}, is_ram ? {28'h0, we} : 32'h0);
    chk("ram_ren", {31'h0, ram_ren}, is_ram ? {31'h0, re} : 32'h0);
    stalls = 0;
    while (bus_stall && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    chk("stall_cycles", stalls, is_ram ? 32'd0 : 32'(len + 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t       x;
    logic [31:0] a;
    logic [3:0]  we;
    int          kind;
    total = 0;
    bad = 0;
    err_model = 1'b0;
    resp_k = 99; resp_data = 32'h0; resp_err = 1'b0;
    ram_rdata = 32'h1234_5678;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 32'hA5A5_0000 + 32'(i * 17);
      ref_mem[i] = 32'hA5A5_0000 + 32'(i * 17);
    end
    addr = 32'h0; w_data = 32'h0; wen = 4'h0; ren = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_bus_stall", {31'h0, bus_stall}, 32'h0);
    chk("rst_p_valid", {31'h0, p_valid}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_r_data_src", r_data, 32'h1234_5678);
    @(posedge clk);
    #1;

    // RAM write then read back-to-back.
    do_tx(32'h0000_0010, 32'h1122_3344, 4'b0011, 1'b0, 0, 32'h0, 1'b0);
    do_tx(32'h0000_0010, 32'h0, 4'h0, 1'b1, 0, 32'h0, 1'b0);
    idle(2);
    // Peripheral read, ready in the 3rd p_valid cycle.
    do_tx(32'h4000_0004, 32'h0, 4'h0, 1'b1, 3, 32'hCAFE_0001, 1'b0);
    idle(1);
    // Ready coincides with the timeout cycle: ready wins.
    do_tx(32'h4000_0008, 32'h0, 4'h0, 1'b1, TMO, 32'hBEEF_0042, 1'b0);
    // Write precedence, held through PDONE, then a RAM read right after.
    do_tx(32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 2, 32'h0, 1'b0);
    do_tx(32'h0000_0010, 32'h0, 4'h0, 1'b1, 0, 32'h0, 1'b0);
    // Timeout, then sticky error seen on a later RAM read.
    do_tx(32'h8000_0100, 32'h0, 4'h0, 1'b1, 99, 32'h0, 1'b0);
    idle(3);
    do_tx(32'h0000_0004, 32'h0, 4'h0, 1'b1, 0, 32'h0, 1'b0);

    // Reset in the middle of a peripheral transfer.
    x.addr = 32'h5000_0008; x.write = 1'b0; x.wstrb = 4'h0; x.wdata = 32'h0; x.len = 8'd2;
    pq.push_back(x);
    resp_k = 99;
    addr = 32'h5000_0008; w_data = 32'h0; wen = 4'h0; ren = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_bus_err", {31'h0, bus_err}, 32'h1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    ren = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_p_valid", {31'h0, p_valid}, 32'h0);
    chk("midrst_bus_stall", {31'h0, bus_stall}, 32'h0);
    chk("midrst_bus_err", {31'h0, bus_err}, 32'h0);
    rstn = 1'b1;
    err_model = 1'b0;
    @(posedge clk);
    #1;

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      if (kind < 2) begin
        a = {4'h0, 22'($urandom), 4'($urandom), 2'b00};
        we = (kind == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        do_tx(a, $urandom, we, (kind == 1), 0, 32'h0, 1'b0);
      end else begin
        a = {4'($urandom_range(1, 15)), 26'($urandom), 2'b00};
        we = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
        do_tx(a, $urandom, we, 1'($urandom_range(0, 1)) | (we == 4'h0), $urandom_range(1, 6),
              $urandom, ($urandom_range(0, 5) == 0));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    chk("resp_queue_drained", sq.size(), 32'd0);
    chk("xfer_queue_drained", pq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
